// File: rtl/render_fetch_arbiter.sv
// Arbitrates the single-port grid RAM between the sim engine and a per-scanline row prefetch
// into a ping-pong line buffer, and drives the per-pixel cell fields to the color mapper.
module render_fetch_arbiter #(
    parameter int GRID_W      = 80,
    parameter int GRID_H      = 60,
    parameter int CELL_SHIFT  = 3,
    parameter int SIGNAL_bits = 10,
    parameter int FAIR_N      = 4,
    parameter int ADDR_W      = 13
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   line_start,
    input  logic [5:0]             next_row,
    input  logic [9:0]             DrawX,
    input  logic                   disp_en,
    input  logic                   sim_req,
    input  logic                   sim_we,
    input  logic [ADDR_W-1:0]      sim_addr,
    input  logic [SIGNAL_bits+2:0] sim_wdata,
    output logic                   sim_gnt,
    output logic [SIGNAL_bits+2:0] sim_rdata,
    output logic                   sim_rvalid,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic                   ram_we,
    output logic [SIGNAL_bits+2:0] ram_wdata,
    input  logic [SIGNAL_bits+2:0] ram_rdata,
    output logic                   renderAnt,
    output logic                   renderSugar,
    output logic                   renderNest,
    output logic [SIGNAL_bits-1:0] renderSignal,
    output logic                   fetch_overrun
);

    localparam int DATA_W = SIGNAL_bits + 3;
    localparam int COL_W  = $clog2(GRID_W);
    localparam int K_W    = (FAIR_N > 1) ? $clog2(FAIR_N) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(GRID_W - 1);
    localparam logic [K_W-1:0]   SIM_SLOT = K_W'(FAIR_N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [COL_W-1:0]  col;
    logic [K_W-1:0]    k;
    logic [5:0]        fetch_row;
    logic [5:0]        front_row;
    logic [5:0]        back_row;
    logic [ADDR_W-1:0] row_base;
    logic              front_valid;
    logic              back_valid;
    logic              back_blank;
    logic              front_sel;

    logic              sim_slot;
    logic              render_issue;
    logic              row_in_grid;
    logic [5:0]        front_row_nxt;

    logic              issue_vld_p0;
    logic [COL_W-1:0]  issue_col_p0;
    logic              issue_buf_p0;

    logic              rd_pend;
    logic [DATA_W-1:0] rdata_hold;

    logic [DATA_W-1:0] line_buf [2][GRID_W];

    logic [9:0]        draw_col;
    logic              draw_in_grid;
    logic [DATA_W-1:0] cell_word;

    assign sim_slot    = (k == SIM_SLOT);
    assign row_in_grid = (int'(next_row) < GRID_H);

    // Front row as it will be after the swap step of this line_start.
    always_comb begin
        front_row_nxt = front_row;
        if (back_valid)
            front_row_nxt = back_row;
        else if (back_blank)
            front_row_nxt = '1;
    end

    // Grant decision; everything is held off while reset is asserted.
    always_comb begin
        sim_gnt      = 1'b0;
        render_issue = 1'b0;
        if (Reset_n) begin
            case (state)
                IDLE:  sim_gnt = sim_req;
                FETCH: begin
                    sim_gnt      = sim_req && sim_slot;
                    render_issue = !(sim_req && sim_slot) && !line_start;
                end
                DRAIN: sim_gnt = sim_req;
                default: ;
            endcase
        end
    end

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (sim_gnt) begin
            ram_addr  = sim_addr;
            ram_we    = sim_we;
            ram_wdata = sim_wdata;
        end else if (render_issue) begin
            ram_addr = row_base + ADDR_W'(col);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= IDLE;
            col           <= '0;
            k             <= '0;
            fetch_row     <= '1;
            front_row     <= '1;
            back_row      <= '1;
            row_base      <= '0;
            front_valid   <= 1'b0;
            back_valid    <= 1'b0;
            back_blank    <= 1'b0;
            front_sel     <= 1'b0;
            fetch_overrun <= 1'b0;
        end else begin
            fetch_overrun <= 1'b0;
            if (line_start) begin
                if (back_valid) begin
                    front_sel   <= ~front_sel;
                    front_row   <= back_row;
                    front_valid <= 1'b1;
                    back_valid  <= 1'b0;
                end else if (back_blank) begin
                    front_row   <= '1;
                    front_valid <= 1'b0;
                end
                back_blank    <= 1'b0;
                fetch_overrun <= (state != IDLE);
                if (row_in_grid && (next_row != front_row_nxt)) begin
                    state     <= FETCH;
                    col       <= '0;
                    k         <= '0;
                    fetch_row <= next_row;
                    row_base  <= ADDR_W'(next_row) * ADDR_W'(GRID_W);
                end else begin
                    state      <= IDLE;
                    back_blank <= !row_in_grid;
                end
            end else begin
                case (state)
                    FETCH: begin
                        k <= sim_slot ? '0 : k + 1'b1;
                        if (render_issue) begin
                            col <= col + 1'b1;
                            if (col == LAST_COL)
                                state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        back_valid <= 1'b1;
                        back_row   <= fetch_row;
                        state      <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // p0: render read tag, lines up with ram_rdata one cycle after issue
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            issue_vld_p0 <= 1'b0;
        else
            issue_vld_p0 <= render_issue;
    end

    always_ff @(posedge Clk) begin
        issue_col_p0 <= col;
        issue_buf_p0 <= ~front_sel;
    end

    always_ff @(posedge Clk) begin
        if (issue_vld_p0)
            line_buf[issue_buf_p0][issue_col_p0] <= ram_rdata;
    end

    // Sim read return; rdata_hold keeps the last word between reads.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_pend    <= 1'b0;
            rdata_hold <= '0;
        end else begin
            rd_pend <= sim_gnt && !sim_we;
            if (rd_pend)
                rdata_hold <= ram_rdata;
        end
    end

    assign sim_rvalid = rd_pend;
    assign sim_rdata  = rd_pend ? ram_rdata : rdata_hold;

    // p1: per-pixel lookup into the front buffer
    assign draw_col     = DrawX >> CELL_SHIFT;
    assign draw_in_grid = (int'(draw_col) < GRID_W);
    assign cell_word    = line_buf[front_sel][draw_col[COL_W-1:0]];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            {renderAnt, renderSugar, renderNest, renderSignal} <= '0;
        else if (disp_en && draw_in_grid && front_valid)
            {renderAnt, renderSugar, renderNest, renderSignal} <= cell_word;
        else
            {renderAnt, renderSugar, renderNest, renderSignal} <= '0;
    end

endmodule

// File: tb/tb_render_fetch_arbiter.sv
// Bench for render_fetch_arbiter: behavioural grid RAM, address/render scoreboards,
// table-driven render vectors and hand-written arbitration, overrun and reset sequences.
module tb_render_fetch_arbiter;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        line_start = 1'b0;
    logic [5:0]  next_row = '0;
    logic [9:0]  DrawX = '0;
    logic        disp_en = 1'b0;
    logic        sim_req = 1'b1;
    logic        sim_we = 1'b1;
    logic [12:0] sim_addr = '0;
    logic [12:0] sim_wdata = '0;
    logic        sim_gnt;
    logic [12:0] sim_rdata;
    logic        sim_rvalid;
    logic [12:0] ram_addr;
    logic        ram_we;
    logic [12:0] ram_wdata;
    logic [12:0] ram_rdata = '0;
    logic        renderAnt, renderSugar, renderNest;
    logic [9:0]  renderSignal;
    logic        fetch_overrun;

    int total = 0;
    int bad = 0;
    int ovr_cnt = 0;

    logic [12:0] aq[$];
    logic [12:0] rq[$];

    render_fetch_arbiter dut (
        .Clk(Clk), .Reset_n(Reset_n), .line_start(line_start), .next_row(next_row),
        .DrawX(DrawX), .disp_en(disp_en), .sim_req(sim_req), .sim_we(sim_we),
        .sim_addr(sim_addr), .sim_wdata(sim_wdata), .sim_gnt(sim_gnt),
        .sim_rdata(sim_rdata), .sim_rvalid(sim_rvalid), .ram_addr(ram_addr),
        .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .renderAnt(renderAnt), .renderSugar(renderSugar), .renderNest(renderNest),
        .renderSignal(renderSignal), .fetch_overrun(fetch_overrun)
    );

    always #5 Clk = ~Clk;

    function automatic logic [12:0] gold(input int a);
        logic [12:0] v;
        v = 13'(a * 181 + 29) ^ 13'(a >> 3);
        if (a == 5 * 80 + 79) v = 13'h1ABC;
        return v;
    endfunction

    function automatic logic [12:0] exp_render(input int row, input int x, input logic de);
        int c;
        c = x >> 3;
        if (!de || c >= 80) return 13'h0;
        return gold(row * 80 + c);
    endfunction

    // Grid RAM model: 1-cycle read latency, loaded from gold() on the first edge.
    logic [12:0] ram [0:8191];
    logic ram_ready = 1'b0;
    always @(posedge Clk) begin
        if (!ram_ready) begin
            for (int a = 0; a < 8192; a++) ram[a] <= gold(a);
            ram_ready <= 1'b1;
        end else begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            ram_rdata <= ram[ram_addr];
        end
    end

    always @(negedge Clk) if (fetch_overrun === 1'b1) ovr_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, required finish");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    task automatic pulse_ls(input int row);
        @(negedge Clk);
        line_start = 1'b1;
        next_row   = 6'(row);
        @(negedge Clk);
        line_start = 1'b0;
    endtask

    task automatic render_vec(input logic [9:0] x, input logic de, input logic [12:0] exp,
                              input string nm);
        @(negedge Clk);
        DrawX   = x;
        disp_en = de;
        rq.push_back(exp);
        @(negedge Clk);
        #1;
        check(nm, {renderAnt, renderSugar, renderNest, renderSignal}, rq.pop_front());
    endtask

    // Starts at the negedge of the first FETCH cycle; ends on the cycle of the last issue.
    task automatic fetch_check(input int row, input bit sim_on, input string nm);
        int issued = 0;
        int c = 0;
        int g = 0;
        for (int i = 0; i < 80; i++) aq.push_back(13'(row * 80 + i));
        while (issued < 80 && c < 300) begin
            #1;
            if (sim_on) check({nm, " gnt_slot"}, sim_gnt, (c % 4 == 3));
            if (sim_gnt) begin
                g++;
                check({nm, " gnt_addr"}, ram_addr, sim_addr);
            end else begin
                check({nm, " fetch_addr"}, ram_addr, aq.pop_front());
                check({nm, " fetch_we"}, ram_we, 0);
                issued++;
            end
            c++;
            if (issued < 80) @(negedge Clk);
        end
        check({nm, " issued"}, issued, 80);
        aq.delete();
        if (sim_on) begin
            check({nm, " cycles"}, c, 106);
            check({nm, " grants"}, g, 26);
        end else begin
            check({nm, " cycles"}, c, 80);
        end
    endtask

    typedef struct {
        logic [9:0]  x;
        logic        de;
        logic [12:0] exp;
        string       nm;
    } rvec_t;

    rvec_t tbl [10];
    int ovr_base;

    initial begin
        tbl[0] = '{10'd16,   1'b1, exp_render(5, 16, 1'b1),   "cell_5_2"};
        tbl[1] = '{10'd0,    1'b1, exp_render(5, 0, 1'b1),    "cell_5_0"};
        tbl[2] = '{10'd639,  1'b1, exp_render(5, 639, 1'b1),  "cell_5_79_ant"};
        tbl[3] = '{10'd640,  1'b1, 13'h0,                     "col_80_blank"};
        tbl[4] = '{10'd1023, 1'b1, 13'h0,                     "col_127_blank"};
        tbl[5] = '{10'd639,  1'b0, 13'h0,                     "disp_off"};
        tbl[6] = '{10'd300,  1'b1, exp_render(5, 300, 1'b1),  "cell_5_37"};
        tbl[7] = '{10'd632,  1'b1, exp_render(5, 632, 1'b1),  "cell_5_79_lo"};
        tbl[8] = '{10'd15,   1'b1, exp_render(5, 15, 1'b1),   "cell_5_1"};
        tbl[9] = '{10'd16,   1'b0, 13'h0,                     "disp_off_2"};

        // Reset state, with a sim write pending
        repeat (3) @(negedge Clk);
        #1;
        check("rst sim_gnt", sim_gnt, 0);
        check("rst ram_we", ram_we, 0);
        check("rst render", {renderAnt, renderSugar, renderNest, renderSignal}, 0);
        check("rst overrun", fetch_overrun, 0);
        check("rst rvalid", sim_rvalid, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        sim_req = 1'b0;
        sim_we  = 1'b0;

        // Row 5 prefetch with an idle sim port
        pulse_ls(5);
        fetch_check(5, 1'b0, "t1");
        @(negedge Clk);
        @(negedge Clk);
        render_vec(10'd16, 1'b1, 13'h0, "front_invalid");

        // Swap in row 5; same row requested so no fetch, sim owns the port
        pulse_ls(5);
        for (int i = 0; i < 100; i++) begin
            sim_req  = 1'($urandom_range(0, 1));
            sim_we   = 1'b0;
            sim_addr = 13'($urandom_range(0, 8191));
            #1;
            check("t3 gnt_eq_req", sim_gnt, sim_req);
            if (sim_req) check("t3 addr", ram_addr, sim_addr);
            @(negedge Clk);
        end
        sim_req = 1'b0;

        foreach (tbl[i]) render_vec(tbl[i].x, tbl[i].de, tbl[i].exp, tbl[i].nm);

        // Sim write held through a fetch of row 7
        sim_req   = 1'b1;
        sim_we    = 1'b1;
        sim_addr  = 13'd100;
        sim_wdata = 13'h0ABC;
        pulse_ls(7);
        fetch_check(7, 1'b1, "t2");
        @(negedge Clk);
        #1;
        check("t2 drain_gnt", sim_gnt, 1);
        @(negedge Clk);
        sim_we = 1'b0;
        #1;
        check("t2 rd_gnt", sim_gnt, 1);
        @(negedge Clk);
        sim_req = 1'b0;
        #1;
        check("t2 rvalid", sim_rvalid, 1);
        check("t2 rdata", sim_rdata, 13'h0ABC);
        @(negedge Clk);
        #1;
        check("t2 rvalid_drop", sim_rvalid, 0);
        check("t2 rdata_hold", sim_rdata, 13'h0ABC);

        // Overrun: second line_start mid-fetch under constant sim reads
        ovr_base = ovr_cnt;
        sim_req  = 1'b1;
        sim_we   = 1'b0;
        sim_addr = 13'd3;
        pulse_ls(9);
        repeat (48) @(negedge Clk);
        pulse_ls(11);
        #1;
        check("t4 overrun_pulse", fetch_overrun, 1);
        fetch_check(11, 1'b1, "t4");
        @(negedge Clk);
        @(negedge Clk);
        sim_req = 1'b0;
        check("t4 overrun_count", ovr_cnt - ovr_base, 1);
        render_vec(10'd24, 1'b1, exp_render(7, 24, 1'b1), "t4 front_kept");

        // Reset in the middle of a fetch with a sim write waiting
        pulse_ls(13);
        render_vec(10'd24, 1'b1, exp_render(11, 24, 1'b1), "t6 front_11");
        repeat (15) @(negedge Clk);
        @(negedge Clk);
        Reset_n   = 1'b0;
        sim_req   = 1'b1;
        sim_we    = 1'b1;
        sim_addr  = 13'd200;
        sim_wdata = 13'h1555;
        #1;
        check("t6 ram_we", ram_we, 0);
        check("t6 sim_gnt", sim_gnt, 0);
        check("t6 render", {renderAnt, renderSugar, renderNest, renderSignal}, 0);
        check("t6 rvalid", sim_rvalid, 0);
        repeat (3) begin
            @(negedge Clk);
            #1;
            check("t6 ram_we_hold", ram_we, 0);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        sim_req = 1'b0;
        sim_we  = 1'b0;
        check("t6 ram_untouched", ram[200], gold(200));
        render_vec(10'd24, 1'b1, 13'h0, "t6 front_cleared");
        pulse_ls(13);
        fetch_check(13, 1'b0, "t6");
        @(negedge Clk);
        @(negedge Clk);
        pulse_ls(13);
        render_vec(10'd100, 1'b1, exp_render(13, 100, 1'b1), "t6 cell_13_12");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
